// File: rtl/sequenciador_quadro_pkg.sv
// Package: sequenciador_quadro_pkg
// Purpose : shared state codes and output decoding for the frame sequencer.
//           The state encoding is also used by anything that decodes
//           db_estado_sequenciador.
// Contents: estado_t   - FSM state codes
//           saidas_t   - registered output bundle driven by the FSM
//           saidas_de  - output values that belong to a given state
//           em_espera  - states that wait on a coordinator's fim_*
//           em_passada - states that belong to an ongoing frame pass
//           proximo_estagio - fixed coordinator order within a pass
package sequenciador_quadro_pkg;

    typedef enum logic [4:0] {
        INICIAL       = 5'b00000,
        ESPERA_QUADRO = 5'b00001,
        MOVE_AST      = 5'b00010,
        MOVE_TIRO     = 5'b00011,
        AST_TIRO      = 5'b00100,
        AST_NAVE      = 5'b00101,
        FIM_QUADRO    = 5'b00110,
        ERRO          = 5'b11111
    } estado_t;

    // cordena[0]=move asteroids, [1]=move shots, [2]=asteroid/shot, [3]=asteroid/ship
    typedef struct packed {
        logic [3:0] cordena;
        logic       fim_quadro;
        logic       erro_timeout;
    } saidas_t;

    function automatic saidas_t saidas_de(input estado_t e);
        saidas_t s;
        s.cordena      = 4'b0000;
        s.fim_quadro   = 1'b0;
        s.erro_timeout = 1'b0;
        case (e)
            MOVE_AST:   s.cordena      = 4'b0001;
            MOVE_TIRO:  s.cordena      = 4'b0010;
            AST_TIRO:   s.cordena      = 4'b0100;
            AST_NAVE:   s.cordena      = 4'b1000;
            FIM_QUADRO: s.fim_quadro   = 1'b1;
            ERRO:       s.erro_timeout = 1'b1;
            default:    s.cordena      = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic em_espera(input estado_t e);
        return (e == MOVE_AST) || (e == MOVE_TIRO) || (e == AST_TIRO) || (e == AST_NAVE);
    endfunction

    function automatic logic em_passada(input estado_t e);
        return em_espera(e) || (e == FIM_QUADRO);
    endfunction

    function automatic estado_t proximo_estagio(input estado_t e);
        estado_t p;
        case (e)
            MOVE_AST:  p = MOVE_TIRO;
            MOVE_TIRO: p = AST_TIRO;
            AST_TIRO:  p = AST_NAVE;
            AST_NAVE:  p = FIM_QUADRO;
            default:   p = ERRO;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sequenciador_quadro_contador.sv
// Module : contador_m
// Purpose: modulo-M counter with synchronous clear and enable. fim_ciclo is
//          high while the count sits at M-1 (the value it wraps from).
// Ports  : clock     in  system clock, rising edge
//          reset     in  synchronous, active-high
//          clr       in  synchronous clear to zero (wins over en)
//          en        in  count enable
//          fim_ciclo out count == M-1
module contador_m
    import sequenciador_quadro_pkg::*;
#(
    parameter int M = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic fim_ciclo
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] MAX = W'(M - 1);

    logic [W-1:0] cont_r;

    // count register: clear has priority, wraps from M-1 back to zero
    always_ff @(posedge clock) begin
        if (reset) begin
            cont_r <= '0;
        end else if (clr) begin
            cont_r <= '0;
        end else if (en) begin
            if (cont_r == MAX) begin
                cont_r <= '0;
            end else begin
                cont_r <= cont_r + W'(1);
            end
        end else begin
            cont_r <= cont_r;
        end
    end

    // wrap flag
    always_comb begin
        fim_ciclo = (cont_r == MAX);
    end

endmodule

// File: rtl/sequenciador_quadro.sv
// Module : sequenciador_quadro
// Purpose: frame-level initiator. A free-running frame timer triggers one
//          pass per frame through four coordinators (move asteroids, move
//          shots, asteroid/shot, asteroid/ship), each driven with a
//          start-level / done handshake and guarded by a watchdog.
// Ports  : clock, reset (sync, active-high), iniciar, pausa
//          cordena_* out - start levels (Moore, registered)
//          fim_*     in  - done from each coordinator
//          fim_quadro out - one-cycle pulse at end of pass
//          quadro_perdido out - sticky, tick arrived during a pass
//          erro_timeout out - high while in ERRO
//          db_estado_sequenciador out [4:0] - current state code
module sequenciador_quadro
    import sequenciador_quadro_pkg::*;
#(
    parameter int FRAME_CICLOS = 1000,
    parameter int TIMEOUT      = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       pausa,
    output logic       cordena_move_asteroides,
    input  logic       fim_move_asteroides,
    output logic       cordena_move_tiros,
    input  logic       fim_move_tiros,
    output logic       cordena_asteroide_tiro,
    input  logic       fim_cordena_asteroide_tiro,
    output logic       cordena_asteroide_nave,
    input  logic       fim_asteroide_nave,
    output logic       fim_quadro,
    output logic       quadro_perdido,
    output logic       erro_timeout,
    output logic [4:0] db_estado_sequenciador
);

    estado_t estado_r;
    saidas_t saidas_r;
    logic    quadro_perdido_r;

    logic timer_en_s;
    logic timer_wrap_s;
    logic tick_s;
    logic em_espera_s;
    logic fim_atual_s;
    logic wd_clr_s;
    logic wd_wrap_s;
    logic estouro_s;

    // timer gating, done selection for the current stage and watchdog control
    always_comb begin
        timer_en_s  = (estado_r != INICIAL) && (estado_r != ERRO) && !pausa;
        tick_s      = timer_wrap_s && timer_en_s;
        em_espera_s = em_espera(estado_r);
        case (estado_r)
            MOVE_AST:  fim_atual_s = fim_move_asteroides;
            MOVE_TIRO: fim_atual_s = fim_move_tiros;
            AST_TIRO:  fim_atual_s = fim_cordena_asteroide_tiro;
            AST_NAVE:  fim_atual_s = fim_asteroide_nave;
            default:   fim_atual_s = 1'b0;
        endcase
        // clearing on the leaving edge makes the count start at zero on entry
        wd_clr_s  = !em_espera_s || fim_atual_s;
        estouro_s = em_espera_s && !fim_atual_s && wd_wrap_s;
    end

    contador_m #(.M(FRAME_CICLOS)) u_timer (
        .clock     (clock),
        .reset     (reset),
        .clr       (1'b0),
        .en        (timer_en_s),
        .fim_ciclo (timer_wrap_s)
    );

    contador_m #(.M(TIMEOUT)) u_watchdog (
        .clock     (clock),
        .reset     (reset),
        .clr       (wd_clr_s),
        .en        (em_espera_s),
        .fim_ciclo (wd_wrap_s)
    );

    // sequencer FSM; outputs are registered together with the state they belong to
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r         <= INICIAL;
            saidas_r         <= saidas_de(INICIAL);
            quadro_perdido_r <= 1'b0;
        end else begin
            if (tick_s && em_passada(estado_r)) begin
                quadro_perdido_r <= 1'b1;
            end else begin
                quadro_perdido_r <= quadro_perdido_r;
            end
            case (estado_r)
                INICIAL: begin
                    if (iniciar) begin
                        estado_r <= ESPERA_QUADRO;
                        saidas_r <= saidas_de(ESPERA_QUADRO);
                    end
                end
                ESPERA_QUADRO: begin
                    if (tick_s) begin
                        estado_r <= MOVE_AST;
                        saidas_r <= saidas_de(MOVE_AST);
                    end
                end
                MOVE_AST, MOVE_TIRO, AST_TIRO, AST_NAVE: begin
                    if (fim_atual_s) begin
                        estado_r <= proximo_estagio(estado_r);
                        saidas_r <= saidas_de(proximo_estagio(estado_r));
                    end else if (estouro_s) begin
                        estado_r <= ERRO;
                        saidas_r <= saidas_de(ERRO);
                    end
                end
                FIM_QUADRO: begin
                    estado_r <= ESPERA_QUADRO;
                    saidas_r <= saidas_de(ESPERA_QUADRO);
                end
                ERRO: begin
                    estado_r <= ERRO;
                    saidas_r <= saidas_de(ERRO);
                end
                default: begin
                    estado_r <= ERRO;
                    saidas_r <= saidas_de(ERRO);
                end
            endcase
        end
    end

    // port mapping of the registered outputs
    always_comb begin
        cordena_move_asteroides = saidas_r.cordena[0];
        cordena_move_tiros      = saidas_r.cordena[1];
        cordena_asteroide_tiro  = saidas_r.cordena[2];
        cordena_asteroide_nave  = saidas_r.cordena[3];
        fim_quadro              = saidas_r.fim_quadro;
        erro_timeout            = saidas_r.erro_timeout;
        quadro_perdido          = quadro_perdido_r;
        db_estado_sequenciador  = estado_r;
    end

endmodule

// File: tb/tb_sequenciador_quadro.sv
// Directed bench for sequenciador_quadro with FRAME_CICLOS=20, TIMEOUT=16,
// clock period 2. Responders are modelled per stage: fim tied high, stuck
// low, or raised a fixed number of cycles after the start level rises.
module tb_sequenciador_quadro;
    import sequenciador_quadro_pkg::*;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       pausa;
    logic       cordena_move_asteroides;
    logic       fim_move_asteroides;
    logic       cordena_move_tiros;
    logic       fim_move_tiros;
    logic       cordena_asteroide_tiro;
    logic       fim_cordena_asteroide_tiro;
    logic       cordena_asteroide_nave;
    logic       fim_asteroide_nave;
    logic       fim_quadro;
    logic       quadro_perdido;
    logic       erro_timeout;
    logic [4:0] db_estado;

    logic [3:0] starts_s;
    logic [3:0] fim_v;
    logic       tie;
    logic [3:0] stuck;
    int         atraso;
    int         cnt [4];
    int         checks;
    int         failures;

    sequenciador_quadro #(.FRAME_CICLOS(20), .TIMEOUT(16)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .iniciar                    (iniciar),
        .pausa                      (pausa),
        .cordena_move_asteroides    (cordena_move_asteroides),
        .fim_move_asteroides        (fim_move_asteroides),
        .cordena_move_tiros         (cordena_move_tiros),
        .fim_move_tiros             (fim_move_tiros),
        .cordena_asteroide_tiro     (cordena_asteroide_tiro),
        .fim_cordena_asteroide_tiro (fim_cordena_asteroide_tiro),
        .cordena_asteroide_nave     (cordena_asteroide_nave),
        .fim_asteroide_nave         (fim_asteroide_nave),
        .fim_quadro                 (fim_quadro),
        .quadro_perdido             (quadro_perdido),
        .erro_timeout               (erro_timeout),
        .db_estado_sequenciador     (db_estado)
    );

    assign starts_s = {cordena_asteroide_nave, cordena_asteroide_tiro,
                       cordena_move_tiros, cordena_move_asteroides};

    initial clock = 1'b0;
    always #1 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    // advance to the next falling edge, then update the responder models
    task automatic passo();
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            if (starts_s[i]) cnt[i] = cnt[i] + 1;
            else             cnt[i] = 0;
            fim_v[i] = tie ? 1'b1 : (starts_s[i] && (cnt[i] > atraso));
            if (stuck[i]) fim_v[i] = 1'b0;
        end
        fim_move_asteroides        = fim_v[0];
        fim_move_tiros             = fim_v[1];
        fim_cordena_asteroide_tiro = fim_v[2];
        fim_asteroide_nave         = fim_v[3];
    endtask

    task automatic espera_estado(input logic [4:0] alvo, input int limite, input string tag,
                                 output int n);
        n = 0;
        while (db_estado != alvo && n < limite) begin
            passo();
            n++;
        end
        verifica(tag, db_estado, alvo);
    endtask

    initial begin
        #100000;
        $display("FAIL tb_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int desvios;
        checks = 0; failures = 0;
        reset = 1'b1; iniciar = 1'b0; pausa = 1'b0;
        tie = 1'b1; stuck = 4'b0000; atraso = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        fim_move_asteroides = 1'b0; fim_move_tiros = 1'b0;
        fim_cordena_asteroide_tiro = 1'b0; fim_asteroide_nave = 1'b0;

        // 1: reset state, then minimum-latency pass with all fim tied high
        repeat (5) passo();
        verifica("reset_estado", db_estado, INICIAL);
        verifica("reset_starts", starts_s, 4'b0000);
        verifica("reset_fim_quadro", fim_quadro, 1'b0);
        verifica("reset_perdido", quadro_perdido, 1'b0);
        verifica("reset_erro", erro_timeout, 1'b0);
        reset = 1'b0; iniciar = 1'b1;
        passo();
        verifica("inicia_espera", db_estado, ESPERA_QUADRO);
        espera_estado(MOVE_AST, 40, "primeiro_tick", n);
        verifica("latencia_tick", n, 20);
        verifica("start_move_ast", starts_s, 4'b0001);
        for (int c = 3; c <= 6; c++) begin
            passo();
            verifica("seq_estado", db_estado, c);
            verifica("seq_starts", starts_s, (c == 6) ? 4'b0000 : (4'b0001 << (c - 2)));
            verifica("seq_fim_quadro", fim_quadro, (c == 6) ? 1'b1 : 1'b0);
        end
        passo();
        verifica("volta_espera", db_estado, ESPERA_QUADRO);
        verifica("pulso_unico", fim_quadro, 1'b0);
        n = 1;
        while (!fim_quadro && n < 60) begin
            passo();
            n++;
        end
        verifica("periodo_fim_quadro", n, 20);

        // 2: each responder raises fim 3 cycles after its start -> start high 4 cycles
        tie = 1'b0; atraso = 3;
        espera_estado(MOVE_AST, 40, "tick_resposta3", n);
        verifica("fim_quadro_ate_tick", n, 16);
        for (int s = 0; s < 4; s++) begin
            verifica("ordem_estado", db_estado, 2 + s);
            verifica("ordem_start", starts_s, 4'b0001 << s);
            n = 0;
            while (starts_s[s] && n < 20) begin
                n++;
                passo();
            end
            verifica("start_4_ciclos", n, 4);
        end
        verifica("fim_apos_17", fim_quadro, 1'b1);

        // 3: asteroid/shot coordinator never answers -> watchdog to ERRO
        reset = 1'b1;
        repeat (2) passo();
        verifica("reset2_estado", db_estado, INICIAL);
        reset = 1'b0; tie = 1'b1; stuck = 4'b0100;
        passo();
        espera_estado(AST_TIRO, 40, "chega_ast_tiro", n);
        n = 0;
        while (db_estado == AST_TIRO && n < 40) begin
            n++;
            passo();
        end
        verifica("ciclos_ate_timeout", n, 16);
        verifica("erro_estado", db_estado, ERRO);
        verifica("erro_flag", erro_timeout, 1'b1);
        verifica("erro_starts", starts_s, 4'b0000);
        repeat (5) passo();
        verifica("erro_persiste", db_estado, ERRO);
        reset = 1'b1;
        passo();
        verifica("erro_reset_estado", db_estado, INICIAL);
        verifica("erro_reset_flag", erro_timeout, 1'b0);

        // 4: slow responders (12 cycles, within the 16-cycle watchdog) make a pass
        //    take 53 cycles, so the next tick lands mid-pass
        stuck = 4'b0000; tie = 1'b0; atraso = 12;
        reset = 1'b0;
        passo();
        espera_estado(MOVE_AST, 40, "tick_lento", n);
        for (int k = 1; k <= 60; k++) begin
            passo();
            if (k == 19) verifica("perdido_antes", quadro_perdido, 1'b0);
            if (k == 20) verifica("perdido_apos_tick", quadro_perdido, 1'b1);
            if (k == 52) verifica("lento_fim_quadro", db_estado, FIM_QUADRO);
            if (k == 58) verifica("sem_passada_extra", db_estado, ESPERA_QUADRO);
            if (k == 60) verifica("passada_normal", db_estado, MOVE_AST);
        end
        verifica("perdido_persiste", quadro_perdido, 1'b1);

        // 5: pausa at timer count 10 for 50 cycles
        reset = 1'b1;
        passo();
        verifica("reset_limpa_perdido", quadro_perdido, 1'b0);
        reset = 1'b0; tie = 1'b1; atraso = 0;
        passo();
        verifica("pausa_espera", db_estado, ESPERA_QUADRO);
        repeat (10) passo();
        pausa = 1'b1;
        desvios = 0;
        for (int k = 0; k < 50; k++) begin
            passo();
            if (db_estado != ESPERA_QUADRO) desvios++;
        end
        pausa = 1'b0;
        verifica("pausa_sem_tick", desvios, 0);
        repeat (9) passo();
        verifica("pausa_ainda_espera", db_estado, ESPERA_QUADRO);
        tie = 1'b0; atraso = 3;
        passo();
        verifica("tick_apos_pausa", db_estado, MOVE_AST);

        // 6: reset in the middle of MOVE_TIRO
        espera_estado(MOVE_TIRO, 10, "chega_move_tiro", n);
        verifica("move_tiro_start", cordena_move_tiros, 1'b1);
        reset = 1'b1;
        passo();
        verifica("reset_meio_estado", db_estado, INICIAL);
        verifica("reset_meio_starts", starts_s, 4'b0000);
        verifica("reset_meio_fim", fim_quadro, 1'b0);
        verifica("reset_meio_erro", erro_timeout, 1'b0);
        verifica("reset_meio_perdido", quadro_perdido, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
